// File: rtl/clint_v2_pkg.sv
// Shared encodings for the core-local interrupt controller: FSM states,
// cause codes, CSR indices, mstatus/mtvec field positions and trap opcodes.
package clint_v2_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_MRET    = 3'd4
  } state_e;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [4:0] CAUSE_ECALL    = 5'd11;
  localparam logic [4:0] CAUSE_EBREAK   = 5'd3;
  localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_IRQ_BASE = 16;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/clint_irq_arb.sv
// Fixed-priority arbiter over masked interrupt requests; lowest index wins.
module clint_irq_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] pend_i,
  output logic         vld_o,
  output logic [3:0]   idx_o,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    vld_o    = |pend_i;
    idx_o    = '0;
    onehot_o = '0;
    // Scan downwards so the lowest pending line is the final assignment.
    for (int k = N - 1; k >= 0; k--) begin
      if (pend_i[k]) begin
        idx_o       = 4'(k);
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clint_v2.sv
// Core-local interrupt controller: sequences mepc/mstatus/mcause writes for
// traps and interrupts, handles MRET, then strobes the redirect to EX.
module clint_v2
  import clint_v2_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_IRQ   = 4,
  parameter int VECTOR_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst_i,
  input  logic [ADDR_W-1:0]  inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  input  logic               div_started_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [DATA_W-1:0]  csr_mtvec,
  input  logic [DATA_W-1:0]  csr_mepc,
  input  logic [DATA_W-1:0]  csr_mstatus,
  input  logic [DATA_W-1:0]  csr_mie,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [ADDR_W-1:0]  waddr_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [ADDR_W-1:0]  int_addr_o,
  output logic               int_assert_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    epc_q, epc_d;
  logic [DATA_W-1:0]    cause_q, cause_d;
  logic [3:0]           idx_q, idx_d;
  logic [NUM_IRQ-1:0]   line_q, line_d;
  logic                 async_q, async_d;

  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]    int_addr_q, int_addr_d;
  logic                 int_assert_q, int_assert_d;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;

  logic [NUM_IRQ-1:0]   pend;
  logic                 arb_vld;
  logic [3:0]           arb_idx;
  logic [NUM_IRQ-1:0]   arb_onehot;
  logic                 is_ecall, is_ebreak, is_mret, trigger;
  logic [4:0]           irq_code_now, irq_code_q;
  logic [ADDR_W-1:0]    trap_base, trap_target;
  logic                 unused_csr_mie;

  assign unused_csr_mie = ^csr_mie;

  assign pend = irq_i & csr_mie[MIE_IRQ_BASE +: NUM_IRQ];

  clint_irq_arb #(.N(NUM_IRQ)) u_arb (
    .pend_i   (pend),
    .vld_o    (arb_vld),
    .idx_o    (arb_idx),
    .onehot_o (arb_onehot)
  );

  assign is_ecall     = (inst_i == INST_ECALL);
  assign is_ebreak    = (inst_i == INST_EBREAK);
  assign is_mret      = (inst_i == INST_MRET);
  assign irq_code_now = CAUSE_IRQ_BASE + {1'b0, arb_idx};
  assign irq_code_q   = CAUSE_IRQ_BASE + {1'b0, idx_q};

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    line_d  = line_q;
    async_d = async_q;
    trigger = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A trap instruction blocks lower-priority sources while the divider is busy.
        if (is_ecall || is_ebreak) begin
          if (!div_started_i) begin
            trigger = 1'b1;
            state_d = S_MEPC;
            epc_d   = jump_flag_i ? (jump_addr_i - ADDR_W'(4)) : inst_addr_i;
            cause_d = DATA_W'(is_ecall ? CAUSE_ECALL : CAUSE_EBREAK);
            idx_d   = '0;
            line_d  = '0;
            async_d = 1'b0;
          end
        end else if (is_mret) begin
          trigger = 1'b1;
          state_d = S_MRET;
        end else if (csr_mstatus[MSTATUS_MIE] && arb_vld) begin
          trigger = 1'b1;
          state_d = S_MEPC;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = {1'b1, (DATA_W-1)'(irq_code_now)};
          idx_d   = arb_idx;
          line_d  = arb_onehot;
          async_d = 1'b1;
        end
      end
      S_MEPC:    state_d = S_MSTATUS;
      S_MSTATUS: state_d = S_MCAUSE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign trap_base = {csr_mtvec[ADDR_W-1:2], 2'b00};

  always_comb begin
    trap_target = trap_base;
    if ((VECTOR_EN != 0) && (csr_mtvec[1:0] == MTVEC_VECTORED) && async_q)
      trap_target = trap_base + (ADDR_W'(irq_code_q) << 2);
  end

  always_comb begin
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_addr_d   = '0;
    int_assert_d = 1'b0;
    ack_d        = '0;
    case (state_q)
      S_MEPC: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(CSR_MEPC);
        data_d  = DATA_W'(epc_q);
      end
      S_MSTATUS: begin
        we_d                 = 1'b1;
        waddr_d              = ADDR_W'(CSR_MSTATUS);
        data_d               = csr_mstatus;
        data_d[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
        data_d[MSTATUS_MIE]  = 1'b0;
      end
      S_MCAUSE: begin
        we_d         = 1'b1;
        waddr_d      = ADDR_W'(CSR_MCAUSE);
        data_d       = cause_q;
        int_assert_d = 1'b1;
        int_addr_d   = trap_target;
        ack_d        = async_q ? line_q : '0;
      end
      S_MRET: begin
        we_d                 = 1'b1;
        waddr_d              = ADDR_W'(CSR_MSTATUS);
        data_d               = csr_mstatus;
        data_d[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
        data_d[MSTATUS_MPIE] = 1'b1;
        int_assert_d         = 1'b1;
        int_addr_d           = ADDR_W'(csr_mepc);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      idx_q        <= '0;
      line_q       <= '0;
      async_q      <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_addr_q   <= '0;
      int_assert_q <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      idx_q        <= idx_d;
      line_q       <= line_d;
      async_q      <= async_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_addr_q   <= int_addr_d;
      int_assert_q <= int_assert_d;
      ack_q        <= ack_d;
    end
  end

  assign hold_flag_o  = trigger | (state_q != S_IDLE);
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_addr_o   = int_addr_q;
  assign int_assert_o = int_assert_q;
  assign irq_ack_o    = ack_q;

endmodule

// File: tb/tb_clint_v2.sv
// Directed bench for clint_v2: trap, interrupt, MRET and reset sequences.
module tb_clint_v2;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_started_i;
  logic [3:0]  irq_i;
  logic [31:0] csr_mtvec, csr_mepc, csr_mstatus, csr_mie;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;
  logic [3:0]  irq_ack_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clint_v2 dut (
    .clk           (clk),
    .rst           (rst),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .div_started_i (div_started_i),
    .irq_i         (irq_i),
    .csr_mtvec     (csr_mtvec),
    .csr_mepc      (csr_mepc),
    .csr_mstatus   (csr_mstatus),
    .csr_mie       (csr_mie),
    .hold_flag_o   (hold_flag_o),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .data_o        (data_o),
    .int_addr_o    (int_addr_o),
    .int_assert_o  (int_assert_o),
    .irq_ack_o     (irq_ack_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".we"}, {31'd0, we_o}, 32'd0);
    chk({tag, ".assert"}, {31'd0, int_assert_o}, 32'd0);
    chk({tag, ".addr"}, int_addr_o, 32'd0);
    chk({tag, ".ack"}, {28'd0, irq_ack_o}, 32'd0);
  endtask

  // Caller applies the trigger in cycle T; this checks T..T+5.
  task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] mst,
                          input logic [31:0] cause, input logic [31:0] target, input logic [3:0] ack);
    #1;
    chk({tag, ".hold_T"}, {31'd0, hold_flag_o}, 32'd1);
    step();
    inst_i = NOP; jump_flag_i = 1'b0; irq_i = '0;
    #1;
    chk({tag, ".hold_T1"}, {31'd0, hold_flag_o}, 32'd1);
    chk({tag, ".we_T1"}, {31'd0, we_o}, 32'd0);
    step();
    chk({tag, ".mepc_we"}, {31'd0, we_o}, 32'd1);
    chk({tag, ".mepc_addr"}, waddr_o, 32'h341);
    chk({tag, ".mepc_dat"}, data_o, epc);
    step();
    chk({tag, ".mst_addr"}, waddr_o, 32'h300);
    chk({tag, ".mst_dat"}, data_o, mst);
    chk({tag, ".mst_assert"}, {31'd0, int_assert_o}, 32'd0);
    step();
    chk({tag, ".mcause_addr"}, waddr_o, 32'h342);
    chk({tag, ".mcause_dat"}, data_o, cause);
    chk({tag, ".assert"}, {31'd0, int_assert_o}, 32'd1);
    chk({tag, ".target"}, int_addr_o, target);
    chk({tag, ".ack"}, {28'd0, irq_ack_o}, {28'd0, ack});
    chk({tag, ".hold_T4"}, {31'd0, hold_flag_o}, 32'd0);
    step();
    chk_quiet({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1;
    inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
    div_started_i = 1'b0; irq_i = '0;
    csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0; csr_mie = '0;
    #22;
    chk_quiet("reset");
    chk("reset.hold", {31'd0, hold_flag_o}, 32'd0);
    chk("reset.waddr", waddr_o, 32'd0);
    step();
    rst = 1'b0;
    step();

    // ECALL, direct mtvec
    csr_mtvec = 32'h80; csr_mstatus = 32'h8;
    inst_i = ECALL; inst_addr_i = 32'h100;
    trap_seq("ecall", 32'h100, 32'h80, 32'd11, 32'h80, 4'b0000);

    // EBREAK in a jump shadow
    step();
    inst_i = EBREAK; inst_addr_i = 32'h500; jump_flag_i = 1'b1; jump_addr_i = 32'h208;
    trap_seq("ebreak", 32'h204, 32'h80, 32'd3, 32'h80, 4'b0000);

    // Vectored interrupt on line 2; irq drops right after T
    step();
    csr_mtvec = 32'h81; csr_mie = 32'h0004_0000; inst_addr_i = 32'h40;
    irq_i = 4'b0100;
    trap_seq("irq2_vec", 32'h40, 32'h80, 32'h8000_0012, 32'hC8, 4'b0100);

    // Two lines pending, both enabled: line 1 wins
    step();
    csr_mie = 32'h0006_0000; inst_addr_i = 32'h44;
    irq_i = 4'b0110;
    trap_seq("irq_prio", 32'h44, 32'h80, 32'h8000_0011, 32'hC4, 4'b0010);

    // Line 1 masked by mie; direct mode; interrupted jump target becomes mepc
    step();
    csr_mtvec = 32'h80; csr_mie = 32'h0004_0000; inst_addr_i = 32'h48;
    jump_flag_i = 1'b1; jump_addr_i = 32'h600;
    irq_i = 4'b0110;
    trap_seq("irq_mask", 32'h600, 32'h80, 32'h8000_0012, 32'h80, 4'b0100);

    // Global MIE clear: nothing taken
    step();
    csr_mie = 32'h0006_0000; csr_mstatus = 32'h0; irq_i = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mie0.hold", {31'd0, hold_flag_o}, 32'd0);
      chk("mie0.we", {31'd0, we_o}, 32'd0);
      step();
    end
    irq_i = '0; csr_mstatus = 32'h8;

    // ECALL held off while the divider is busy, taken once it frees
    inst_i = ECALL; inst_addr_i = 32'h100; div_started_i = 1'b1;
    #1;
    chk("div.hold", {31'd0, hold_flag_o}, 32'd0);
    step();
    chk("div.we", {31'd0, we_o}, 32'd0);
    div_started_i = 1'b0;
    trap_seq("div_ecall", 32'h100, 32'h80, 32'd11, 32'h80, 4'b0000);

    // MRET
    step();
    csr_mstatus = 32'h80; csr_mepc = 32'h300; inst_i = MRET;
    #1;
    chk("mret.hold", {31'd0, hold_flag_o}, 32'd1);
    step();
    inst_i = NOP;
    #1;
    chk("mret.we_T1", {31'd0, we_o}, 32'd0);
    step();
    chk("mret.we", {31'd0, we_o}, 32'd1);
    chk("mret.waddr", waddr_o, 32'h300);
    chk("mret.dat", data_o, 32'h88);
    chk("mret.assert", {31'd0, int_assert_o}, 32'd1);
    chk("mret.target", int_addr_o, 32'h300);
    step();
    chk_quiet("mret.after");

    // Reset while the mstatus write is being sequenced
    csr_mstatus = 32'h8;
    inst_i = ECALL; inst_addr_i = 32'h100;
    step();
    inst_i = NOP;
    step();
    chk("rst_mid.we_before", {31'd0, we_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid.hold", {31'd0, hold_flag_o}, 32'd0);
    chk("rst_mid.data", data_o, 32'd0);
    step();
    rst = 1'b0;
    step();
    inst_i = ECALL; inst_addr_i = 32'h120;
    trap_seq("post_rst", 32'h120, 32'h80, 32'd11, 32'h80, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_v2.md
Name: clint_v2

Overview:
- Next-generation core-local interrupt controller.
- Handles synchronous traps (ECALL, EBREAK) and MRET as before; adds NUM_IRQ level-sensitive asynchronous interrupt lines gated by mie/mstatus.MIE, correct MPIE save/restore and optional vectored mtvec dispatch.
- Sits between ID/EX, ctrl and csr_reg: sequences one CSR write per cycle, then redirects EX to the handler or return address.

Parameters:
- ADDR_W, 32, instruction/bus address width.
- DATA_W, 32, CSR data width.
- NUM_IRQ, 4, async interrupt lines (1..16); line k maps to mie bit 16+k and mcause code 16+k.
- VECTOR_EN, 1, 1 = honour mtvec.MODE=01 (vectored) for async interrupts; 0 = always direct.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- inst_i  in  32  instruction in ID.
- inst_addr_i  in  ADDR_W  PC of inst_i.
- jump_flag_i  in  1  EX jump taken this cycle.
- jump_addr_i  in  ADDR_W  EX jump target.
- div_started_i  in  1  divider busy.
- irq_i  in  NUM_IRQ  level interrupt requests.
- csr_mtvec, csr_mepc, csr_mstatus, csr_mie  in  DATA_W each  current CSR values.
- hold_flag_o  out  1  pipeline hold to ctrl.
- we_o  out  1  CSR write enable.
- waddr_o  out  ADDR_W  CSR write address ({20'h0, csr index}).
- data_o  out  DATA_W  CSR write data.
- int_addr_o  out  ADDR_W  redirect target to EX.
- int_assert_o  out  1  one-cycle redirect strobe.
- irq_ack_o  out  NUM_IRQ  one-hot ack, pulses with int_assert_o for the serviced line.

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, latched cause/epc 0; takes effect immediately, including mid-sequence.
- Trigger evaluation in IDLE only, priority: (1) ECALL/EBREAK with div_started_i=0 -> SYNC; with divider busy -> no action, re-evaluated next cycle; (2) MRET -> RET; (3) async: pend = irq_i & csr_mie[16+NUM_IRQ-1:16], taken if csr_mstatus[3]=1 and pend!=0 -> ASYNC, lowest index wins.
- Trigger sampled at cycle T; hold_flag_o = trigger | (state!=IDLE), combinational.
- Latched at T: epc = jump_flag_i ? jump_addr_i-4 : inst_addr_i for SYNC; jump_flag_i ? jump_addr_i : inst_addr_i for ASYNC (interrupted insn not executed). Cause: ECALL 11, EBREAK 3, async {1'b1, 16+idx}. Selected line index also latched.
- States: IDLE -> MEPC (T+1) -> MSTATUS (T+2) -> MCAUSE (T+3) -> IDLE; IDLE -> MRET (T+1) -> IDLE.
- Outputs registered from state (one cycle later):
  - MEPC: write mepc=epc at T+2.
  - MSTATUS: write mstatus with MPIE(bit7)=MIE(bit3), MIE=0 at T+3.
  - MCAUSE: write mcause=cause at T+4; int_assert_o=1 at T+4.
  - MRET: write mstatus with MIE=MPIE, MPIE=1 at T+2; int_assert_o=1, int_addr_o=csr_mepc at T+2.
- Trap target: base={csr_mtvec[ADDR_W-1:2],2'b00}. If VECTOR_EN and mtvec[1:0]=01 and async, target=base+4*code; otherwise base. irq_ack_o one-hot for async traps, else 0.
- All outputs return to 0 the cycle after their strobe. No back-to-back trap: IDLE is re-entered before the next evaluation.
- irq_i dropping after T does not cancel the sequence.
- Sequence is not interrupted by new triggers.

Decomposition:
- Shared package/defines: state encodings, cause codes (11, 3, 16+k), CSR indices, mstatus bit positions (MIE=3, MPIE=7), mtvec mode values.
- One sub-module: clint_irq_arb (masked fixed-priority arbiter: pend -> valid, index, one-hot).

Test Plan:
- ECALL at 0x100, mtvec=0x80 -> mepc=0x100, mstatus MIE 1->0 with MPIE=1, mcause=11, int_assert_o with int_addr_o=0x80 at T+4.
- EBREAK with jump_flag_i=1, jump_addr_i=0x208 -> mepc=0x204, mcause=3.
- irq_i[2]=1, mie[18]=1, MIE=1, mtvec=0x81, inst_addr_i=0x40 -> mepc=0x40, mcause=0x80000012, int_addr_o=0xC8, irq_ack_o=4'b0100.
- irq_i=4'b0110 with mie[17]=0 -> line 2 serviced; with MIE=0 -> no trap, hold_flag_o stays 0.
- MRET with mstatus=0x80, mepc=0x300 -> mstatus write 0x88, int_addr_o=0x300 at T+2.
- Assert rst during MSTATUS state -> all outputs 0 immediately; next ECALL runs a full sequence.
